uart_tx: RTL and testbench

- 8N1 UART transmitter. It is the transmit-side partner of the team's 16×-oversampled UART receiver.
- Runs on the same baud×16 tick clock and holds each line bit for exactly TICKS_PER_BIT clocks.
- Bytes come from a producer (keyboard/FSM/ROM reader) through a valid/ready handshake into a small FIFO. The block serialises them LSB-first onto the TX pin.

---
 rtl/uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with input byte FIFO
//
// Purpose:
//   Serialises bytes LSB-first as 8N1 frames: one start bit (0), eight data
//   bits, and one stop bit (1). Each line bit lasts TICKS_PER_BIT clocks.
//   Bytes arrive through a send/ready handshake into a circular FIFO.
//   Frames run back to back with no idle cycles while the FIFO holds data.
//
// Optional feature:
//   Defining UART_TX_STOP2_EN stretches the stop bit to 2*TICKS_PER_BIT clocks.
//   With the default parameters this makes each frame 176 clocks long.
//
// Ports:
//   clk         baud x16 tick clock; all logic runs on its rising edge
//   reset       synchronous, active-high reset
//   data_in     byte to queue; sampled when send & ready
//   send        producer valid strobe
//   ready       FIFO not full (combinational from the FIFO level)
//   bit_out     serial TX line; idles high
//   busy        a frame is on the line or the FIFO is non-empty
//   fifo_level  number of bytes currently queued
module uart_tx #(
  parameter int TICKS_PER_BIT = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          send,
  output logic                          ready,
  output logic                          bit_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          stop_last;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          push, pop;
  logic [7:0]    head;

`ifdef UART_TX_STOP2_EN
  // Marks that the first of the two stop-bit periods has already elapsed.
  logic          stop_second, stop_second_nx;
  assign stop_last = stop_second;
`else
  assign stop_last = 1'b1;
`endif

  assign ready      = (level != LVL_FULL);
  assign push       = send & ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign busy       = (state != IDLE) | (level != '0);

  // FIFO storage. It needs no reset because the pointers define the contents.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // The pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_STOP2_EN
      stop_second <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      tick    <= tick_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
`ifdef UART_TX_STOP2_EN
      stop_second <= stop_second_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    tick_nx    = tick;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    pop        = 1'b0;
    bit_out    = 1'b1;
`ifdef UART_TX_STOP2_EN
    stop_second_nx = stop_second;
`endif
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop      = 1'b1;
          shreg_nx = head;
          tick_nx  = '0;
          state_nx = START;
        end
      end
      START: begin
        bit_out = 1'b0;
        if (tick == TICK_LAST) begin
          tick_nx    = '0;
          bit_idx_nx = '0;
          state_nx   = DATA;
        end else begin
          tick_nx = tick + TW'(1);
        end
      end
      DATA: begin
        bit_out = shreg[0];
        if (tick == TICK_LAST) begin
          tick_nx  = '0;
          shreg_nx = shreg >> 1;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
`ifdef UART_TX_STOP2_EN
            stop_second_nx = 1'b0;
`endif
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end else begin
          tick_nx = tick + TW'(1);
        end
      end
      STOP: begin
        bit_out = 1'b1;
        if (tick == TICK_LAST) begin
          tick_nx = '0;
          if (!stop_last) begin
`ifdef UART_TX_STOP2_EN
            stop_second_nx = 1'b1;
`endif
          end else if (level != '0) begin
            // Chain straight into the next start bit without an idle cycle.
            pop      = 1'b1;
            shreg_nx = head;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          tick_nx = tick + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized scoreboard bench for uart_tx
module tb_uart_tx;

  localparam int TPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam int FRAME = (9 + STOP_BITS) * TPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       send = 1'b0;
  logic       ready, bit_out, busy;
  logic [2:0] fifo_level;

  uart_tx #(.TICKS_PER_BIT(TPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .send(send),
    .ready(ready), .bit_out(bit_out), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic chk(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  // Reference model: pending byte queue plus remaining clocks of the current frame.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] cur_byte = 8'h00;
  int         rem = 0;
  bit         mdl_on = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mq.delete();
      sb.delete();
      rem = 0;
      mdl_on = 1'b1;
    end else begin
      bit acc;
      acc = send && (mq.size() < DEPTH);
      if (mq.size() > 0 && rem <= 1) begin
        cur_byte = mq.pop_front();
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (acc) begin
        mq.push_back(data_in);
        sb.push_back(data_in);
      end
    end
  end

  function automatic int exp_bit();
    int t;
    if (rem == 0) return 1;
    t = FRAME - rem;
    if (t < TPB) return 0;
    if (t < 9 * TPB) return int'(cur_byte[(t / TPB) - 1]);
    return 1;
  endfunction

  // Line-level checks against the model on every cycle.
  always @(negedge clk) begin
    if (mdl_on) begin
      chk("bit_out", int'(bit_out), exp_bit());
      chk("busy", int'(busy), int'(rem > 0 || mq.size() > 0));
      chk("ready", int'(ready), int'(mq.size() < DEPTH));
      chk("fifo_level", int'(fifo_level), mq.size());
    end
  end

  // Scoreboard monitor: a behavioural receiver sampling mid-bit.
  bit         rx_active = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && bit_out == 1'b0) begin
        rx_active = 1'b1;
        rx_t = 0;
      end else if (rx_active) begin
        rx_t++;
      end
      if (rx_active) begin
        if (rx_t == TPB / 2) chk("rx_start", int'(bit_out), 0);
        if (rx_t >= TPB + TPB / 2 && rx_t < 9 * TPB && ((rx_t - TPB / 2) % TPB) == 0)
          rx_byte[(rx_t - TPB - TPB / 2) / TPB] = bit_out;
        for (int s = 0; s < STOP_BITS; s++)
          if (rx_t == (9 + s) * TPB + TPB / 2) chk("rx_stop", int'(bit_out), 1);
        if (rx_t == FRAME - 1) begin
          if (sb.size() == 0) chk("rx_unexpected", 1, 0);
          else chk("rx_byte", int'(rx_byte), int'(sb.pop_front()));
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] b);
    send = 1'b1;
    data_in = b;
    step(1);
  endtask

  initial begin
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(50);

    push(8'hA5);
    send = 1'b0;
    data_in = 8'h3E;
    step(FRAME + 40);

    push(8'h00); push(8'hFF); push(8'h55); push(8'h3C);
    send = 1'b0;
    step(4 * FRAME + 40);

    push(8'h77);
    send = 1'b0;
    step(20);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
    send = 1'b0;
    step(5 * FRAME + 40);

    push(8'h81); push(8'h11); push(8'h22);
    send = 1'b0;
    step(68);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(3 * FRAME);

    push(8'h12); push(8'h34);
    send = 1'b0;
    step(2 * FRAME + 40);

    for (int i = 0; i < 600; i++) begin
      send = ($urandom_range(0, 5) == 0);
      data_in = 8'($urandom);
      step(1);
    end
    send = 1'b0;
    step((DEPTH + 2) * FRAME);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
